// File: rtl/instr_loader_pkg.sv
// Purpose: shared constants and FSM encoding for the instruction loader and cpu_core decode.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_loader_pkg;

    localparam int INSTR_W   = 16;
    localparam int OPC_W     = 4;
    localparam int IMM_W     = INSTR_W - OPC_W;
    // Needs one extra bit above log2(INSTR_W) so a full frame (16) is representable.
    localparam int BIT_CNT_W = $clog2(INSTR_W) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/instr_loader_sync.sv
// Purpose: multi-flop synchronizer for one async input, with rise/fall pulses on the synced level.
// Latency: level_o follows async_i after SYNC_STAGES clk; rise_o/fall_o are combinational off the sync chain.
// Backpressure: none; free-running.
//
// Ports:
//   clk      system clock
//   rst      synchronous reset, active-high (clears chain and history to 0)
//   async_i  asynchronous input
//   level_o  synchronized level
//   rise_o   1-cycle pulse when level_o goes 0->1
//   fall_o   1-cycle pulse when level_o goes 1->0
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
        // History flop holds the previous synced level for edge detection.
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  =  level_o & ~hist_q;
    assign fall_o  = ~level_o &  hist_q;

endmodule

// File: rtl/instr_loader.sv
// Purpose: assemble 16-bit instructions from a 3-wire serial link, MSB first; debounce step button.
// Latency: ser_frame_i fall -> inst_done/frame_err = SYNC_STAGES+1 clk; btn_edge registered with debounced level.
// Backpressure: none; consumers must take inst_done/btn_edge pulses when they occur.
//
// Ports:
//   clk, rst                       system clock, synchronous active-high reset
//   ser_clk_i/ser_data_i/ser_frame_i  async serial link (rising ser_clk samples data)
//   btn_i                          async raw step button
//   opcode, instr                  last valid instruction, held between frames
//   inst_done                      1-cycle pulse when opcode/instr update
//   btn_edge                       1-cycle pulse on debounced 0->1
//   frame_err                      1-cycle pulse when a frame ended with bit count != 16
//   busy                           high while receiving a frame
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 1000,
    parameter int DEB_W       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_clk_i,
    input  logic             ser_data_i,
    input  logic             ser_frame_i,
    input  logic             btn_i,
    output logic [OPC_W-1:0] opcode,
    output logic [IMM_W-1:0] instr,
    output logic             inst_done,
    output logic             btn_edge,
    output logic             frame_err,
    output logic             busy
);

    localparam logic [BIT_CNT_W-1:0] FULL_CNT = BIT_CNT_W'(INSTR_W);
    localparam logic [DEB_W-1:0]     DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    // ---------------- synchronizers ----------------
    logic clk_s,   clk_rise,   clk_fall;
    logic frame_s, frame_rise, frame_fall;
    logic data_s,  data_rise,  data_fall;
    logic btn_s,   btn_rise,   btn_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(clk), .rst(rst), .async_i(ser_clk_i),
        .level_o(clk_s), .rise_o(clk_rise), .fall_o(clk_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_frame (
        .clk(clk), .rst(rst), .async_i(ser_frame_i),
        .level_o(frame_s), .rise_o(frame_rise), .fall_o(frame_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk), .rst(rst), .async_i(ser_data_i),
        .level_o(data_s), .rise_o(data_rise), .fall_o(data_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_btn (
        .clk(clk), .rst(rst), .async_i(btn_i),
        .level_o(btn_s), .rise_o(btn_rise), .fall_o(btn_fall)
    );

    // Only the levels/edges the design needs are consumed; the rest are unused by intent.
    logic unused_sync;
    assign unused_sync = clk_s ^ clk_fall ^ data_rise ^ data_fall ^ btn_rise ^ btn_fall;

    // ---------------- state ----------------
    state_t                 state_q, state_d;
    logic [INSTR_W-1:0]     sr_q, sr_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   ovf_q, ovf_d;
    logic [OPC_W-1:0]       opcode_q, opcode_d;
    logic [IMM_W-1:0]       instr_q, instr_d;
    logic                   inst_done_q, inst_done_d;
    logic                   frame_err_q, frame_err_d;
    logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
    logic                   btn_stable_q, btn_stable_d;
    logic                   btn_edge_q, btn_edge_d;

    // State register (plus datapath flops).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            opcode_q     <= '0;
            instr_q      <= '0;
            inst_done_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            deb_cnt_q    <= '0;
            btn_stable_q <= 1'b0;
            btn_edge_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            ovf_q        <= ovf_d;
            opcode_q     <= opcode_d;
            instr_q      <= instr_d;
            inst_done_q  <= inst_done_d;
            frame_err_q  <= frame_err_d;
            deb_cnt_q    <= deb_cnt_d;
            btn_stable_q <= btn_stable_d;
            btn_edge_q   <= btn_edge_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (frame_rise) state_d = SHIFT;
            SHIFT:   if (frame_fall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame datapath and output pulses.
    always_comb begin
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        ovf_d       = ovf_q;
        opcode_d    = opcode_q;
        instr_d     = instr_q;
        inst_done_d = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_rise) begin
                    sr_d      = '0;
                    bit_cnt_d = '0;
                    ovf_d     = 1'b0;
                end
            end
            SHIFT: begin
                // Frame end has priority over a coincident ser_clk rise.
                if (frame_fall) begin
                    if (bit_cnt_q == FULL_CNT && !ovf_q) begin
                        opcode_d    = sr_q[INSTR_W-1 -: OPC_W];
                        instr_d     = sr_q[IMM_W-1:0];
                        inst_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (clk_rise && frame_s) begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    // Once 16 bits are in, further bits only flag overflow.
                    if (bit_cnt_q < FULL_CNT) sr_d  = {sr_q[INSTR_W-2:0], data_s};
                    else                      ovf_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Debouncer: the level must differ from the stable value for DEB_CYCLES consecutive cycles.
    always_comb begin
        deb_cnt_d    = deb_cnt_q;
        btn_stable_d = btn_stable_q;
        if (btn_s == btn_stable_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            btn_stable_d = btn_s;
            deb_cnt_d    = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
        btn_edge_d = btn_stable_d & ~btn_stable_q;
    end

    assign opcode    = opcode_q;
    assign instr     = instr_q;
    assign inst_done = inst_done_q;
    assign frame_err = frame_err_q;
    assign btn_edge  = btn_edge_q;
    assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ser_clk_i = 1'b0, ser_data_i = 1'b0, ser_frame_i = 1'b0, btn_i = 1'b0;
    logic [3:0]  opcode;
    logic [11:0] instr;
    logic        inst_done, btn_edge, frame_err, busy;

    int checks = 0;
    int errors = 0;
    int btn_pulses = 0;

    typedef struct {
        bit          is_err;
        logic [15:0] val;   // new value for a done, held value for an error
    } exp_t;

    exp_t exp_frame_q[$];
    int   exp_btn_q[$];

    always #5 clk = ~clk;

    instr_loader dut (
        .clk(clk), .rst(rst),
        .ser_clk_i(ser_clk_i), .ser_data_i(ser_data_i), .ser_frame_i(ser_frame_i),
        .btn_i(btn_i),
        .opcode(opcode), .instr(instr),
        .inst_done(inst_done), .btn_edge(btn_edge), .frame_err(frame_err), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            ser_data_i = v[n-1-i];
            wait_clk(3);
            ser_clk_i = 1'b1;
            wait_clk(3);
            ser_clk_i = 1'b0;
        end
    endtask

    // aligned_end: one extra ser_clk rise lands in the same cycle as the frame fall.
    task automatic send_frame(input logic [31:0] v, input int n, input bit aligned_end);
        ser_frame_i = 1'b1;
        wait_clk(4);
        send_bits(v, n);
        wait_clk(3);
        if (aligned_end) begin
            ser_data_i  = 1'b1;
            ser_clk_i   = 1'b1;
            ser_frame_i = 1'b0;
            wait_clk(3);
            ser_clk_i   = 1'b0;
        end else begin
            ser_frame_i = 1'b0;
        end
        wait_clk(8);
    endtask

    function automatic exp_t mk(input bit e, input logic [15:0] v);
        exp_t x;
        x.is_err = e;
        x.val    = v;
        return x;
    endfunction

    // Monitor: pops expectations whenever the DUT pulses an output.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (inst_done || frame_err) begin
                if (exp_frame_q.size() == 0) begin
                    check("unexpected_frame_pulse", {30'd0, inst_done, frame_err}, 32'd0);
                end else begin
                    x = exp_frame_q.pop_front();
                    check("pulse_kind", {31'd0, frame_err}, {31'd0, x.is_err});
                    check("pulse_single", {31'd0, inst_done & frame_err}, 32'd0);
                    check("frame_value", {16'd0, opcode, instr}, {16'd0, x.val});
                end
            end
            if (btn_edge) begin
                btn_pulses++;
                if (exp_btn_q.size() == 0) check("unexpected_btn_edge", 32'd1, 32'd0);
                else void'(exp_btn_q.pop_front());
            end
        end
    end

    initial begin
        // Reset state
        wait_clk(5);
        check("rst_opcode", {28'd0, opcode}, 32'd0);
        check("rst_instr", {20'd0, instr}, 32'd0);
        check("rst_pulses", {29'd0, inst_done, frame_err, btn_edge}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_clk(3);

        // 1. valid frame 0xA5C3
        exp_frame_q.push_back(mk(1'b0, 16'hA5C3));
        ser_frame_i = 1'b1;
        wait_clk(4);
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        send_bits(32'hA5C3, 16);
        wait_clk(3);
        ser_frame_i = 1'b0;
        wait_clk(8);
        check("busy_after", {31'd0, busy}, 32'd0);
        check("opcode_A5C3", {28'd0, opcode}, 32'hA);
        check("instr_A5C3", {20'd0, instr}, 32'h5C3);

        // 2. short and long frames: errors, value held
        exp_frame_q.push_back(mk(1'b1, 16'hA5C3));
        send_frame(32'h7FFF, 15, 1'b0);
        exp_frame_q.push_back(mk(1'b1, 16'hA5C3));
        send_frame(32'h1FFFF, 17, 1'b0);
        check("held_after_err", {16'd0, opcode, instr}, 32'hA5C3);

        // 3. ser_clk rise coincides with frame fall: extra bit ignored
        exp_frame_q.push_back(mk(1'b0, 16'h3C5A));
        send_frame(32'h3C5A, 16, 1'b1);
        check("aligned_value", {16'd0, opcode, instr}, 32'h3C5A);

        // 4. button bounce then stable press, then release
        for (int i = 0; i < 5; i++) begin
            btn_i = ~btn_i;
            wait_clk(100);
        end
        btn_i = 1'b0;
        wait_clk(100);
        check("no_edge_on_bounce", btn_pulses, 0);
        exp_btn_q.push_back(1);
        btn_i = 1'b1;
        wait_clk(2000);
        check("one_edge_on_press", btn_pulses, 1);
        btn_i = 1'b0;
        wait_clk(2000);
        check("no_edge_on_release", btn_pulses, 1);

        // 5. reset mid-frame with frame held high
        ser_frame_i = 1'b1;
        wait_clk(4);
        send_bits(32'hFF, 8);
        rst = 1'b1;
        wait_clk(3);
        check("midrst_value", {16'd0, opcode, instr}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_clk(4);
        check("busy_after_rst_restart", {31'd0, busy}, 32'd1);
        exp_frame_q.push_back(mk(1'b0, 16'h6E21));
        send_bits(32'h6E21, 16);
        wait_clk(3);
        ser_frame_i = 1'b0;
        wait_clk(8);
        check("post_rst_value", {16'd0, opcode, instr}, 32'h6E21);

        // 6. back-to-back frames, 2 idle cycles apart
        exp_frame_q.push_back(mk(1'b0, 16'h1234));
        exp_frame_q.push_back(mk(1'b0, 16'hFFFF));
        ser_frame_i = 1'b1;
        wait_clk(4);
        send_bits(32'h1234, 16);
        wait_clk(3);
        ser_frame_i = 1'b0;
        wait_clk(2);
        ser_frame_i = 1'b1;
        wait_clk(4);
        send_bits(32'hFFFF, 16);
        wait_clk(3);
        ser_frame_i = 1'b0;
        wait_clk(10);
        check("b2b_final", {16'd0, opcode, instr}, 32'hFFFF);

        // Every expected pulse must have been observed.
        check("frame_queue_drained", exp_frame_q.size(), 0);
        check("btn_queue_drained", exp_btn_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
